countdown_sequencer: RTL

//  Control core of the countdown timer: turns raw button inputs into set/start/stop/clear

---
 rtl/countdown_sequencer_pkg.sv | 42 ++++
 rtl/countdown_sequencer_button_edge.sv | 43 ++++
 rtl/countdown_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/countdown_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_sequencer_pkg
// Shared definitions for the countdown timer control core: FSM state encoding,
// seconds wrap value, default tick divider and small counter helper functions.
// -----------------------------------------------------------------------------
package countdown_sequencer_pkg;

    // FSM state encoding (kept as plain 2-bit constants for legacy tooling)
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_PAUSE = 2'd2;
    localparam logic [1:0] STATE_ALARM = 2'd3;

    // Largest seconds value before wrapping to zero
    localparam logic [5:0] SEC_MAX = 6'd59;

    // 1 s tick at 50 MHz
    localparam int DEFAULT_TICK_DIV = 50_000_000;

    // Seconds increment: 59 wraps to 0 without carrying into minutes
    function automatic logic [5:0] sec_inc(input logic [5:0] sec);
        logic [5:0] result;
        if (sec >= SEC_MAX) begin
            result = 6'd0;
        end else begin
            result = sec + 6'd1;
        end
        return result;
    endfunction

    // Minutes increment: max_min wraps to 0
    function automatic logic [6:0] min_inc(input logic [6:0] min, input logic [6:0] max_min);
        logic [6:0] result;
        if (min >= max_min) begin
            result = 7'd0;
        end else begin
            result = min + 7'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/countdown_sequencer_button_edge.sv
// -----------------------------------------------------------------------------
// countdown_sequencer_button_edge
// Two-flop synchroniser for an asynchronous push button followed by a rising
// edge detector. Produces a registered one-cycle pulse; a held button yields a
// single pulse. A raw rise sampled at edge N gives a pulse during cycle N+2.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  asynchronous active-high reset
//   btn   in  1  raw button level, asynchronous to clk
//   pulse out 1  one-cycle command pulse
// -----------------------------------------------------------------------------
module countdown_sequencer_button_edge
    import countdown_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic pulse_r;

    // Synchroniser chain, previous-level flop and registered edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            pulse_r <= sync2_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
// Control core of the countdown timer. Converts raw buttons into prioritised
// commands, holds the MM:SS count, decrements it once per tick while running
// and raises an alarm at 00:00 for ALARM_SECS ticks.
// Ports:
//   CLK_50MHZ        in  1  system clock
//   reset            in  1  asynchronous active-high reset
//   incrementSeconds in  1  raw button
//   incrementMinutes in  1  raw button
//   start            in  1  raw button
//   stop             in  1  raw button
//   delete           in  1  raw button
//   minutes          out 7  current minutes, 0..MAX_MIN
//   seconds          out 6  current seconds, 0..59
//   running          out 1  high while in RUN
//   alarm            out 1  high while in ALARM
//   disp_update      out 1  one-cycle pulse when minutes/seconds changed
// -----------------------------------------------------------------------------
module countdown_sequencer
    import countdown_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 5
) (
    input  logic       CLK_50MHZ,
    input  logic       reset,
    input  logic       incrementSeconds,
    input  logic       incrementMinutes,
    input  logic       start,
    input  logic       stop,
    input  logic       delete,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       alarm,
    output logic       disp_update
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ALM_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_SECS - 1);
    localparam logic [ALM_W-1:0] ALM_ONE  = ALM_W'(1);
    localparam logic [6:0]       MIN_LAST = 7'(MAX_MIN);

    // Raw button pulses
    logic sec_p_s, min_p_s, start_p_s, stop_p_s, del_p_s;
    // Prioritised commands (at most one active)
    logic cmd_sec_s, cmd_min_s, cmd_start_s, cmd_stop_s, cmd_del_s;

    logic [1:0]       state_r, state_next_s;
    logic [6:0]       minutes_r, min_next_s, dec_min_s;
    logic [5:0]       seconds_r, sec_next_s, dec_sec_s;
    logic [PRE_W-1:0] prescaler_r, pre_next_s;
    logic [ALM_W-1:0] alarm_cnt_r, alm_next_s;
    logic             running_r, alarm_r, disp_update_r;
    logic             tick_s, count_zero_s, dec_zero_s;

    countdown_sequencer_button_edge u_btn_sec   (.clk(CLK_50MHZ), .rst(reset), .btn(incrementSeconds), .pulse(sec_p_s));
    countdown_sequencer_button_edge u_btn_min   (.clk(CLK_50MHZ), .rst(reset), .btn(incrementMinutes), .pulse(min_p_s));
    countdown_sequencer_button_edge u_btn_start (.clk(CLK_50MHZ), .rst(reset), .btn(start),            .pulse(start_p_s));
    countdown_sequencer_button_edge u_btn_stop  (.clk(CLK_50MHZ), .rst(reset), .btn(stop),             .pulse(stop_p_s));
    countdown_sequencer_button_edge u_btn_del   (.clk(CLK_50MHZ), .rst(reset), .btn(delete),           .pulse(del_p_s));

    // Lower-priority commands in the same cycle are dropped
    assign cmd_del_s   = del_p_s;
    assign cmd_stop_s  = stop_p_s  & ~del_p_s;
    assign cmd_start_s = start_p_s & ~del_p_s & ~stop_p_s;
    assign cmd_min_s   = min_p_s   & ~del_p_s & ~stop_p_s & ~start_p_s;
    assign cmd_sec_s   = sec_p_s   & ~del_p_s & ~stop_p_s & ~start_p_s & ~min_p_s;

    assign tick_s       = (prescaler_r == PRE_LAST);
    assign count_zero_s = (minutes_r == 7'd0) && (seconds_r == 6'd0);
    assign dec_zero_s   = (dec_min_s == 7'd0) && (dec_sec_s == 6'd0);

    // One-second decrement of the MM:SS count (borrow from minutes at :00)
    always_comb begin
        dec_min_s = minutes_r;
        dec_sec_s = seconds_r;
        if (seconds_r != 6'd0) begin
            dec_sec_s = seconds_r - 6'd1;
        end else if (minutes_r != 7'd0) begin
            dec_sec_s = SEC_MAX;
            dec_min_s = minutes_r - 7'd1;
        end else begin
            dec_sec_s = 6'd0;
            dec_min_s = 7'd0;
        end
    end

    // FSM next state plus count, prescaler and alarm-tick datapath
    always_comb begin
        state_next_s = state_r;
        min_next_s   = minutes_r;
        sec_next_s   = seconds_r;
        pre_next_s   = prescaler_r;
        alm_next_s   = alarm_cnt_r;
        if (cmd_del_s) begin
            state_next_s = STATE_IDLE;
            min_next_s   = 7'd0;
            sec_next_s   = 6'd0;
            pre_next_s   = '0;
            alm_next_s   = '0;
        end else begin
            case (state_r)
                STATE_IDLE: begin
                    pre_next_s = '0;
                    alm_next_s = '0;
                    if (cmd_start_s) begin
                        if (count_zero_s) begin
                            state_next_s = STATE_IDLE;
                        end else begin
                            state_next_s = STATE_RUN;
                        end
                    end else if (cmd_min_s) begin
                        min_next_s = min_inc(minutes_r, MIN_LAST);
                    end else if (cmd_sec_s) begin
                        sec_next_s = sec_inc(seconds_r);
                    end else begin
                        state_next_s = STATE_IDLE;
                    end
                end
                STATE_RUN: begin
                    // Stop freezes the prescaler so PAUSE->RUN resumes mid-second
                    if (cmd_stop_s) begin
                        state_next_s = STATE_PAUSE;
                    end else if (tick_s) begin
                        pre_next_s = '0;
                        min_next_s = dec_min_s;
                        sec_next_s = dec_sec_s;
                        if (dec_zero_s) begin
                            state_next_s = STATE_ALARM;
                            alm_next_s   = '0;
                        end else begin
                            state_next_s = STATE_RUN;
                        end
                    end else begin
                        pre_next_s = prescaler_r + PRE_ONE;
                    end
                end
                STATE_PAUSE: begin
                    if (cmd_start_s) begin
                        state_next_s = STATE_RUN;
                    end else begin
                        state_next_s = STATE_PAUSE;
                    end
                end
                STATE_ALARM: begin
                    if (cmd_start_s || cmd_stop_s) begin
                        state_next_s = STATE_IDLE;
                        pre_next_s   = '0;
                        alm_next_s   = '0;
                    end else if (tick_s) begin
                        pre_next_s = '0;
                        if (alarm_cnt_r >= ALM_LAST) begin
                            state_next_s = STATE_IDLE;
                            alm_next_s   = '0;
                        end else begin
                            alm_next_s = alarm_cnt_r + ALM_ONE;
                        end
                    end else begin
                        pre_next_s = prescaler_r + PRE_ONE;
                    end
                end
                default: begin
                    state_next_s = STATE_IDLE;
                    min_next_s   = 7'd0;
                    sec_next_s   = 6'd0;
                    pre_next_s   = '0;
                    alm_next_s   = '0;
                end
            endcase
        end
    end

    // State, count and registered status/display outputs
    always_ff @(posedge CLK_50MHZ or posedge reset) begin
        if (reset) begin
            state_r       <= STATE_IDLE;
            minutes_r     <= 7'd0;
            seconds_r     <= 6'd0;
            prescaler_r   <= '0;
            alarm_cnt_r   <= '0;
            running_r     <= 1'b0;
            alarm_r       <= 1'b0;
            disp_update_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            minutes_r     <= min_next_s;
            seconds_r     <= sec_next_s;
            prescaler_r   <= pre_next_s;
            alarm_cnt_r   <= alm_next_s;
            running_r     <= (state_next_s == STATE_RUN);
            alarm_r       <= (state_next_s == STATE_ALARM);
            disp_update_r <= (min_next_s != minutes_r) || (sec_next_s != seconds_r);
        end
    end

    assign minutes     = minutes_r;
    assign seconds     = seconds_r;
    assign running     = running_r;
    assign alarm       = alarm_r;
    assign disp_update = disp_update_r;

endmodule
